// File: rtl/fp_div_post_norm.sv
// rtl/fp_div_post_norm.sv - FP divider post stage: normalize, round-to-nearest-even, pack
// Four-state sequence IDLE -> NORM -> ROUND -> PACK; subnormal results flush to signed zero.
module fp_div_post_norm #(
  parameter int EXP  = 8,
  parameter int MANT = 23,
  parameter int QW   = MANT + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sign,
  input  logic signed [EXP+1:0] in_exp,
  input  logic [QW-1:0]         in_q,
  input  logic [QW-1:0]         in_r,
  input  logic                  in_dbz,
  output logic                  busy,
  output logic                  out_valid,
  output logic [EXP+MANT:0]     out_result,
  output logic                  out_ovf,
  output logic                  out_unf,
  output logic                  out_inx,
  output logic                  out_dz
);

  localparam int EW = EXP + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

  state_t               state_q;
  logic                 sign_q, dbz_q, r_nz_q;
  logic signed [EW-1:0] exp_q, e_q;
  logic [QW-1:0]        q_q;
  logic [MANT:0]        m_q;
  logic                 g_q, s_q, inx_q;
  logic                 busy_q, valid_q, ovf_q, unf_q, inx_o_q, dz_q;
  logic [EXP+MANT:0]    result_q;

  logic [MANT:0]        norm_m_d;
  logic                 norm_g_d, norm_s_d;
  logic signed [EW-1:0] norm_e_d;
  logic [MANT+1:0]      m_inc;
  logic [MANT:0]        round_m_d;
  logic signed [EW-1:0] round_e_d;
  logic                 round_inx_d;
  logic [EXP+MANT:0]    result_d;
  logic                 ovf_d, unf_d, inx_o_d, dz_d;

  // Quotient is in [2^(QW-2), 2^QW): at most one bit of left-normalization is needed.
  always_comb begin
    if (q_q[QW-1]) begin
      norm_m_d = q_q[QW-1:2];
      norm_g_d = q_q[1];
      norm_s_d = q_q[0] | r_nz_q;
      norm_e_d = exp_q;
    end else begin
      norm_m_d = q_q[QW-2:1];
      norm_g_d = q_q[0];
      norm_s_d = r_nz_q;
      norm_e_d = exp_q - E_ONE;
    end
  end

  always_comb begin
    m_inc       = {1'b0, m_q} + {{(MANT+1){1'b0}}, 1'b1};
    round_m_d   = m_q;
    round_e_d   = e_q;
    round_inx_d = g_q | s_q;
    if (g_q & (s_q | m_q[0])) begin
      if (m_inc[MANT+1]) begin
        round_m_d = {1'b1, {MANT{1'b0}}};
        round_e_d = e_q + E_ONE;
      end else begin
        round_m_d = m_inc[MANT:0];
      end
    end
  end

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inx_o_d  = 1'b0;
    dz_d     = 1'b0;
    if (dbz_q) begin
      result_d = {sign_q, {EXP{1'b1}}, {MANT{1'b0}}};
      dz_d     = 1'b1;
    end else if (e_q >= E_MAX) begin
      result_d = {sign_q, {EXP{1'b1}}, {MANT{1'b0}}};
      ovf_d    = 1'b1;
      inx_o_d  = 1'b1;
    end else if (e_q <= E_ZERO) begin
      result_d = {sign_q, {(EXP+MANT){1'b0}}};
      unf_d    = 1'b1;
      inx_o_d  = inx_q;
    end else begin
      result_d = {sign_q, e_q[EXP-1:0], m_q[MANT-1:0]};
      inx_o_d  = inx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_o_q  <= 1'b0;
      dz_q     <= 1'b0;
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
      r_nz_q   <= 1'b0;
      exp_q    <= '0;
      q_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            dbz_q   <= in_dbz;
            exp_q   <= in_exp;
            q_q     <= in_q;
            r_nz_q  <= |in_r;
            busy_q  <= 1'b1;
            state_q <= NORM;
          end
        end
        NORM: begin
          m_q     <= norm_m_d;
          g_q     <= norm_g_d;
          s_q     <= norm_s_d;
          e_q     <= norm_e_d;
          state_q <= ROUND;
        end
        ROUND: begin
          m_q     <= round_m_d;
          e_q     <= round_e_d;
          inx_q   <= round_inx_d;
          state_q <= PACK;
        end
        PACK: begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          inx_o_q  <= inx_o_d;
          dz_q     <= dz_d;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;
  assign out_inx    = inx_o_q;
  assign out_dz     = dz_q;

endmodule
